// File: rtl/elixirchip_es1_spu_op_acc.sv
`default_nettype none
// ============================================================================
// Module   : elixirchip_es1_spu_op_acc
// Purpose  : SPU accumulate op with sticky carry/overflow flags and a
//            cke-gated LATENCY-stage output pipeline.
// Options  : ELIXIRCHIP_ES1_SPU_OP_ACC_SATURATE_EN adds clamp-on-carry/overflow.
// Revision : 1.0 - initial release
// ============================================================================
module elixirchip_es1_spu_op_acc #(
  parameter int    LATENCY    = 1,
  parameter int    DATA_BITS  = 8,
  parameter type   data_t     = logic [DATA_BITS-1:0],
  parameter bit    SIGNED     = 1'b0,
  parameter data_t CLEAR_DATA = '0,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cke,
  input  logic                 s_clear,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_carry,
  output logic                 m_overflow
);

  localparam int c_depth      = (LATENCY < 1) ? 1 : LATENCY;
  localparam int c_msb        = DATA_BITS - 1;
  localparam int c_stage_bits = DATA_BITS + 2;
  localparam logic [c_stage_bits-1:0] c_stage_reset = {1'b0, 1'b0, CLEAR_DATA};

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("LATENCY must be >= 1 (DEVICE=%s SIMULATION=%s DEBUG=%s)",
             DEVICE, SIMULATION, DEBUG);
    end
  endgenerate

  data_t              r_acc;
  logic               r_carry;
  logic               r_overflow;
  logic [DATA_BITS:0] w_sum;
  logic               w_carry;
  logic               w_overflow;
  data_t              w_add;

  assign w_sum      = {1'b0, r_acc} + {1'b0, s_data};
  assign w_carry    = w_sum[DATA_BITS];
  // Like-signed operands producing a result of the other sign
  assign w_overflow = SIGNED && (r_acc[c_msb] == s_data[c_msb])
                             && (w_sum[c_msb] != r_acc[c_msb]);

`ifdef ELIXIRCHIP_ES1_SPU_OP_ACC_SATURATE_EN
  localparam data_t c_max_pos = {1'b0, {(DATA_BITS-1){1'b1}}};
  localparam data_t c_min_neg = {1'b1, {(DATA_BITS-1){1'b0}}};

  // Signed overflow direction follows the addend's sign
  always_comb begin
    w_add = w_sum[c_msb:0];
    if (!SIGNED && w_carry) begin
      w_add = '1;
    end else if (SIGNED && w_overflow) begin
      w_add = s_data[c_msb] ? c_min_neg : c_max_pos;
    end
  end
`else
  assign w_add = w_sum[c_msb:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= CLEAR_DATA;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (cke) begin
      if (s_clear) begin
        r_acc      <= s_valid ? s_data : CLEAR_DATA;
        r_carry    <= 1'b0;
        r_overflow <= 1'b0;
      end else if (s_valid) begin
        r_acc      <= w_add;
        r_carry    <= r_carry | w_carry;
        r_overflow <= r_overflow | w_overflow;
      end
    end
  end

  // Stage 0 is the accumulator itself; later stages are plain delays
  logic [c_stage_bits-1:0] w_stage [c_depth];

  assign w_stage[0] = {r_overflow, r_carry, r_acc};

  generate
    for (genvar i = 1; i < c_depth; i++) begin : g_stage
      logic [c_stage_bits-1:0] r_stage;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_stage <= c_stage_reset;
        end else if (cke) begin
          r_stage <= w_stage[i-1];
        end
      end

      assign w_stage[i] = r_stage;
    end
  endgenerate

  assign {m_overflow, m_carry, m_data} = w_stage[c_depth-1];

endmodule
`default_nettype wire

// File: tb/tb_elixirchip_es1_spu_op_acc.sv
`default_nettype none
// Bench for elixirchip_es1_spu_op_acc: three instances (unsigned L=1,
// unsigned L=3 with non-zero clear value, signed L=2) checked against a queue scoreboard.
module tb_elixirchip_es1_spu_op_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, cke, s_clear, s_valid;
  logic [7:0] s_data;
  logic [7:0] d1, d3, ds;
  logic       c1, c3, cs, o1, o3, os;

  elixirchip_es1_spu_op_acc #(.LATENCY(1), .DATA_BITS(8), .SIGNED(1'b0), .CLEAR_DATA(8'h00)) dut_u1 (
    .clk(clk), .reset(reset), .cke(cke), .s_clear(s_clear), .s_data(s_data), .s_valid(s_valid),
    .m_data(d1), .m_carry(c1), .m_overflow(o1));

  elixirchip_es1_spu_op_acc #(.LATENCY(3), .DATA_BITS(8), .SIGNED(1'b0), .CLEAR_DATA(8'hA5)) dut_u3 (
    .clk(clk), .reset(reset), .cke(cke), .s_clear(s_clear), .s_data(s_data), .s_valid(s_valid),
    .m_data(d3), .m_carry(c3), .m_overflow(o3));

  elixirchip_es1_spu_op_acc #(.LATENCY(2), .DATA_BITS(8), .SIGNED(1'b1), .CLEAR_DATA(8'h00)) dut_s (
    .clk(clk), .reset(reset), .cke(cke), .s_clear(s_clear), .s_data(s_data), .s_valid(s_valid),
    .m_data(ds), .m_carry(cs), .m_overflow(os));

  int         lat  [3] = '{1, 3, 2};
  bit         sgn  [3] = '{1'b0, 1'b0, 1'b1};
  logic [7:0] cdat [3] = '{8'h00, 8'hA5, 8'h00};

  logic [7:0] m_acc [3];
  logic       m_car [3];
  logic       m_ovf [3];
  logic [9:0] sbq   [3][$];
  logic [9:0] obs   [3];

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ELIXIRCHIP_ES1_SPU_OP_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always_comb begin
    obs[0] = {o1, c1, d1};
    obs[1] = {o3, c3, d3};
    obs[2] = {os, cs, ds};
  end

  // Reference accumulator built from integer arithmetic
  function automatic void model_step(input int k, input logic clr, input logic vld, input logic [7:0] d);
    int              usum, ssum;
    logic signed [7:0] sa, sd;
    logic            cout, ov;
    if (clr) begin
      m_acc[k] = vld ? d : cdat[k];
      m_car[k] = 1'b0;
      m_ovf[k] = 1'b0;
    end else if (vld) begin
      usum = int'(m_acc[k]) + int'(d);
      sa   = m_acc[k];
      sd   = d;
      ssum = int'(sa) + int'(sd);
      cout = (usum > 255);
      ov   = sgn[k] && (ssum > 127 || ssum < -128);
      m_car[k] = m_car[k] | cout;
      m_ovf[k] = m_ovf[k] | ov;
      m_acc[k] = usum[7:0];
      if (SAT && !sgn[k] && cout) m_acc[k] = 8'hFF;
      else if (SAT && sgn[k] && ov) m_acc[k] = d[7] ? 8'h80 : 8'h7F;
    end
  endfunction

  // One clock: drive inputs, advance model/scoreboard, settle past the edge
  task automatic drive(input logic rst, input logic ck, input logic clr, input logic vld, input logic [7:0] d);
    logic [9:0] gone;
    reset = rst; cke = ck; s_clear = clr; s_valid = vld; s_data = d;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_acc[k] = cdat[k]; m_car[k] = 1'b0; m_ovf[k] = 1'b0;
        sbq[k].delete();
        for (int j = 0; j < lat[k]; j++) sbq[k].push_back({1'b0, 1'b0, cdat[k]});
      end else if (ck) begin
        model_step(k, clr, vld, d);
        sbq[k].push_back({m_ovf[k], m_car[k], m_acc[k]});
        gone = sbq[k].pop_front();
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h33);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs[k] !== sbq[k][0]) begin n_fail++; $display("FAIL reset dut%0d: got %h expected %h", k, obs[k], sbq[k][0]); end
    end
    n_checks++;
    if ({o1, c1, d1} !== 10'h000) begin n_fail++; $display("FAIL reset_u1_const: got %h expected 000", {o1, c1, d1}); end
    n_checks++;
    if (d3 !== 8'hA5) begin n_fail++; $display("FAIL reset_u3_clear_data: got %h expected a5", d3); end
  endtask

  task automatic test_accumulate();
    logic [7:0] in_d  [5] = '{8'h10, 8'h20, 8'h30, 8'h00, 8'h00};
    logic [7:0] exp_v [3] = '{8'h10, 8'h30, 8'h60};
    logic [7:0] h1 [5];
    logic [7:0] h3 [5];
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, (i == 0), (i < 3), in_d[i]);
      h1[i] = d1; h3[i] = d3;
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs[k] !== sbq[k][0]) begin n_fail++; $display("FAIL accumulate dut%0d: got %h expected %h", k, obs[k], sbq[k][0]); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (h1[i] !== exp_v[i]) begin n_fail++; $display("FAIL acc_l1[%0d]: got %h expected %h", i, h1[i], exp_v[i]); end
      n_checks++;
      if (h3[i+2] !== exp_v[i]) begin n_fail++; $display("FAIL acc_l3[%0d]: got %h expected %h", i, h3[i+2], exp_v[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_w;
    exp_w = SAT ? 8'hFF : 8'h01;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h02);
    n_checks++;
    if ({c1, d1} !== {1'b1, exp_w}) begin n_fail++; $display("FAIL wrap: got %h expected %h", {c1, d1}, {1'b1, exp_w}); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h44);
    n_checks++;
    if ({c1, d1} !== {1'b1, exp_w}) begin n_fail++; $display("FAIL carry_sticky: got %h expected %h", {c1, d1}, {1'b1, exp_w}); end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
    n_checks++;
    if ({c1, d1} !== 9'h000) begin n_fail++; $display("FAIL clear: got %h expected 000", {c1, d1}); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs[k] !== sbq[k][0]) begin n_fail++; $display("FAIL wrap dut%0d: got %h expected %h", k, obs[k], sbq[k][0]); end
    end
  endtask

  task automatic test_signed();
    logic [7:0] exp_s;
    exp_s = SAT ? 8'h7F : 8'h80;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h7F);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h01);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    n_checks++;
    if ({os, ds} !== {1'b1, exp_s}) begin n_fail++; $display("FAIL signed_ovf: got %h expected %h", {os, ds}, {1'b1, exp_s}); end
    n_checks++;
    if (o1 !== 1'b0) begin n_fail++; $display("FAIL unsigned_ovf_zero: got %b expected 0", o1); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs[k] !== sbq[k][0]) begin n_fail++; $display("FAIL signed dut%0d: got %h expected %h", k, obs[k], sbq[k][0]); end
    end
  endtask

  task automatic test_clear_valid();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'hF3);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'hF4);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h55);
    n_checks++;
    if ({o1, c1, d1} !== 10'h055) begin n_fail++; $display("FAIL clear_valid: got %h expected 055", {o1, c1, d1}); end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h01);
    n_checks++;
    if (d1 !== 8'h56) begin n_fail++; $display("FAIL restart_add: got %h expected 56", d1); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs[k] !== sbq[k][0]) begin n_fail++; $display("FAIL clear_valid dut%0d: got %h expected %h", k, obs[k], sbq[k][0]); end
    end
  endtask

  task automatic test_cke_freeze();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h11);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h22);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    n_checks++;
    if (d1 !== 8'h11) begin n_fail++; $display("FAIL cke_hold: got %h expected 11", d1); end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h01);
    n_checks++;
    if (d1 !== 8'h12) begin n_fail++; $display("FAIL cke_resume: got %h expected 12", d1); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs[k] !== sbq[k][0]) begin n_fail++; $display("FAIL cke_freeze dut%0d: got %h expected %h", k, obs[k], sbq[k][0]); end
    end
  endtask

  task automatic test_random();
    logic ck, clr, vld;
    for (int i = 0; i < 400; i++) begin
      ck  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 15) == 0);
      vld = ($urandom_range(0, 3) != 0);
      drive(1'b0, ck, clr, vld, 8'($urandom()));
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs[k] !== sbq[k][0]) begin n_fail++; $display("FAIL random[%0d] dut%0d: got %h expected %h", i, k, obs[k], sbq[k][0]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h40);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'hC5);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h09);
    n_checks++;
    if ({o1, c1, d1, o3, c3, d3} !== {10'h000, 10'h0A5}) begin
      n_fail++; $display("FAIL reset_mid: got %h expected 0000a5", {o1, c1, d1, o3, c3, d3});
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs[k] !== sbq[k][0]) begin n_fail++; $display("FAIL reset_mid dut%0d: got %h expected %h", k, obs[k], sbq[k][0]); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; cke = 1'b0; s_clear = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    test_reset();
    test_accumulate();
    test_wrap();
    test_signed();
    test_clear_valid();
    test_cke_freeze();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
